lcd_cpu: RTL and testbench
==========================

// Module: lcd_cpu
// PURPOSE
// - 8-bit accumulator CPU that runs a program from a shared block-RAM and writes characters to the LCD VRAM.
// - Fetches code and data from the 8K×8 RAM through separate write (A) and read (B) ports.
// - Stores to the 1K×8 VRAM through a write-only port.
// - Can stall until the next LCD vsync, so frame updates are paced by the display.
// PARAMETERS
// - RESET_PC  13'h0000  address of the first fetched opcode
// PORTS
// - clk    in   1   system clock; all logic is on the rising edge
// - rst_n  in   1   reset: asynchronous, active-high (1 = reset)
// - vsync  in   1   LCD vertical sync; asynchronous to program flow; rising edge = frame start
// - dout   in   8   RAM read data; valid 1 cycle after ceb=1 samples adb
// - din    out  8   RAM write data
// - ada    out  13  RAM write address
// - cea    out  1   RAM write strobe; 1-cycle pulse
// - adb    out  13  RAM read address
// - ceb    out  1   RAM read enable
// - v_din  out  8   VRAM write data
// - v_ada  out  10  VRAM write address
// - v_cea  out  1   VRAM write strobe; 1-cycle pulse
// BEHAVIOUR
// - Registers: A[7:0], X[7:0], PC[12:0], flags Z and C.
// - Reset state: all registers and flags 0, PC=RESET_PC, FSM in FETCH, every output 0.
// - Memory read timing:
//   - cycle N: drive adb, ceb=1.
//   - cycle N+1: wait.
//   - cycle N+2: capture dout.
//   - ceb stays 0 while no read is in progress.
// - FSM states: FETCH → WAIT → DECODE → (OPLO → WAIT → OPHI → WAIT) → EXEC → FETCH.
//   - Special states: MEMRD (extra read for LDA abs), VWAIT, HALT.
// - Operand format:
//   - 1-byte immediate, or 2-byte little-endian absolute address.
//   - For absolute addresses, bits [15:13] are ignored.
//   - PC increments per fetched byte, wrapping 0x1FFF→0x0000.
// - Opcodes:
//   - 00 NOP.
//   - 01 LDA #i.
//   - 02 LDA a.
//   - 03 STA a: ada=a, din=A, cea=1 for one cycle.
//   - 04 LDX #i.
//   - 05 INX: 8-bit wrap.
//   - 06 ADD #i: 9-bit sum, C=bit8.
//   - 07 SUB #i: C=1 on borrow.
//   - 08 CMP #i: flags as SUB, A unchanged.
//   - 09 JMP a.
//   - 0A JNZ a: jump if Z=0.
//   - 0B STV a: v_ada=a[9:0], v_din=A, v_cea=1 for one cycle.
//   - 0C STVX a: v_ada=(a+X)[9:0], 10-bit wrap.
//   - 0D WVS: stall until a vsync rising edge.
//   - FF HLT: stop permanently until reset.
//   - Any undefined opcode executes as NOP.
// - Flag updates: Z is updated by LDA, LDX, INX, ADD, SUB, CMP (from the result); no other opcode changes flags.
// - WVS rules:
//   - Only an edge detected after entering VWAIT counts.
//   - vsync held high on entry does not release the stall.
// - HALT: all strobes stay 0, PC frozen.
// - Reset asserted mid-instruction:
//   - Immediately returns to the reset state.
//   - Any pending strobe drops at once (asynchronous).
// - Write-port conflicts: cea and v_cea are never high in the same cycle; only one store occurs per instruction.
// CONFIGURATION
// - VSYNC_SYNC_EN defined:
//   - vsync passes through a 2-flop synchronizer before edge detection.
//   - WVS releases 3 cycles after vsync rises.
// - VSYNC_SYNC_EN undefined:
//   - vsync is edge-detected directly.
//   - WVS releases 1 cycle after vsync rises.
//   - Use only when vsync is already in the clk domain.
// TESTING
// - Reset released; program `01 41 0B 05 00 FF`
//   → one v_cea pulse with v_ada=5, v_din=0x41, then halt with ceb idle.
// - `01 FE 06 03 FF`
//   → A=0x01, C=1, Z=0.
// - `01 05 07 05 0A 00 10 FF` → falls through to HLT (Z=1, C=0); no jump to 0x1000.
// - `04 FF 05 0C 00 03 FF`
//   → X wraps to 0x00, Z=1; one VRAM write at v_ada=0x300.
// - `01 77 03 00 10 02 00 10 FF`
//   → RAM[0x1000]=0x77 via a single cea pulse.
//   → Following load returns A=0x77.
// - `0D 01 AA 0B 00 00 FF` with vsync held high at entry
//   → no v_cea until a fresh rising edge of vsync.
//   → Then exactly one write of 0xAA.
//   → Reset asserted during the stall returns all outputs to 0.

Source files
------------

// File: rtl/lcd_cpu.sv
// lcd_cpu: 8-bit accumulator CPU driving the LCD character VRAM.
//
// Runs a program out of an 8Kx8 block RAM (write port A, read port B) and
// stores characters into a 1Kx8 VRAM through a write-only port. The WVS
// instruction stalls until the next LCD vsync rising edge so frame updates
// are paced by the display.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous reset, active HIGH despite the name
//   vsync  in   1   LCD vertical sync, rising edge = frame start
//   dout   in   8   RAM read data, valid the cycle after ceb samples adb
//   din    out  8   RAM write data
//   ada    out  13  RAM write address
//   cea    out  1   RAM write strobe (1-cycle pulse)
//   adb    out  13  RAM read address
//   ceb    out  1   RAM read enable
//   v_din  out  8   VRAM write data
//   v_ada  out  10  VRAM write address
//   v_cea  out  1   VRAM write strobe (1-cycle pulse)
//
// Build option:
//   VSYNC_SYNC_EN  when defined, vsync goes through a 2-flop synchronizer
//                  before edge detection (WVS releases 3 cycles after the
//                  rise); when undefined vsync is edge-detected directly
//                  (1-cycle release) and must already be in the clk domain.
//
// States:
//   state    | meaning
//   S_FETCH  | issue opcode read at PC, PC++
//   S_WAIT   | RAM latency cycle, then go to ret_q
//   S_DECODE | capture opcode, decide operand count
//   S_OPLO   | issue read of first operand byte, PC++
//   S_OPHI   | capture low address byte, issue read of high byte, PC++
//   S_EXEC   | execute using dout as immediate / high address byte
//   S_MEMRD  | capture data for LDA absolute
//   S_VWAIT  | stalled until a vsync rising edge
//   S_HALT   | stopped until reset

module lcd_cpu #(
  parameter logic [12:0] RESET_PC = 13'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic [7:0]  dout,
  output logic [7:0]  din,
  output logic [12:0] ada,
  output logic        cea,
  output logic [12:0] adb,
  output logic        ceb,
  output logic [7:0]  v_din,
  output logic [9:0]  v_ada,
  output logic        v_cea
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_OPLO,
    S_OPHI,
    S_EXEC,
    S_MEMRD,
    S_VWAIT,
    S_HALT
  } state_t;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LDAI  = 8'h01;
  localparam logic [7:0] OP_LDAA  = 8'h02;
  localparam logic [7:0] OP_STA   = 8'h03;
  localparam logic [7:0] OP_LDXI  = 8'h04;
  localparam logic [7:0] OP_INX   = 8'h05;
  localparam logic [7:0] OP_ADDI  = 8'h06;
  localparam logic [7:0] OP_SUBI  = 8'h07;
  localparam logic [7:0] OP_CMPI  = 8'h08;
  localparam logic [7:0] OP_JMP   = 8'h09;
  localparam logic [7:0] OP_JNZ   = 8'h0A;
  localparam logic [7:0] OP_STV   = 8'h0B;
  localparam logic [7:0] OP_STVX  = 8'h0C;
  localparam logic [7:0] OP_WVS   = 8'h0D;
  localparam logic [7:0] OP_HLT   = 8'hFF;

  function automatic logic has_imm(input logic [7:0] op);
    return (op == OP_LDAI) || (op == OP_LDXI) || (op == OP_ADDI) ||
           (op == OP_SUBI) || (op == OP_CMPI);
  endfunction

  function automatic logic has_abs(input logic [7:0] op);
    return (op == OP_LDAA) || (op == OP_STA) || (op == OP_JMP) ||
           (op == OP_JNZ)  || (op == OP_STV) || (op == OP_STVX);
  endfunction

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [12:0] pc_q, pc_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  x_q, x_d;
  logic        z_q, z_d;
  logic        c_q, c_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  lo_q, lo_d;

  // Unqualified combinational outputs; gated by reset below.
  logic [7:0]  din_c;
  logic [12:0] ada_c;
  logic        cea_c;
  logic [12:0] adb_c;
  logic        ceb_c;
  logic [7:0]  v_din_c;
  logic [9:0]  v_ada_c;
  logic        v_cea_c;

  logic        vs_rise;

`ifdef VSYNC_SYNC_EN
  // [0],[1] synchronize, [2] holds the previous synchronized level.
  logic [2:0] vs_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) vs_q <= '0;
    else       vs_q <= {vs_q[1:0], vsync};
  end

  assign vs_rise = vs_q[1] & ~vs_q[2];
`else
  logic vs_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) vs_q <= 1'b0;
    else       vs_q <= vsync;
  end

  assign vs_rise = vsync & ~vs_q;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_FETCH;
      ret_q   <= S_FETCH;
      pc_q    <= RESET_PC;
      a_q     <= '0;
      x_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ir_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      x_q     <= x_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ir_q    <= ir_d;
      lo_q    <= lo_d;
    end
  end

  // In S_EXEC, dout carries either the immediate or the high address byte.
  // Bits [7:5] of the high byte fall outside the 8K space and are dropped.
  logic [12:0] abs_addr;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [7:0]  x_inc;
  logic [9:0]  stvx_addr;

  assign abs_addr  = {dout[4:0], lo_q};
  assign sum9      = {1'b0, a_q} + {1'b0, dout};
  assign diff9     = {1'b0, a_q} - {1'b0, dout};  // bit 8 set on borrow
  assign x_inc     = x_q + 8'd1;
  assign stvx_addr = abs_addr[9:0] + {2'b00, x_q};

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pc_d    = pc_q;
    a_d     = a_q;
    x_d     = x_q;
    z_d     = z_q;
    c_d     = c_q;
    ir_d    = ir_q;
    lo_d    = lo_q;
    din_c   = '0;
    ada_c   = '0;
    cea_c   = 1'b0;
    adb_c   = '0;
    ceb_c   = 1'b0;
    v_din_c = '0;
    v_ada_c = '0;
    v_cea_c = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ceb_c   = 1'b1;
        adb_c   = pc_q;
        pc_d    = pc_q + 13'd1;
        ret_d   = S_DECODE;
        state_d = S_WAIT;
      end

      S_WAIT: state_d = ret_q;

      S_DECODE: begin
        ir_d    = dout;
        state_d = (has_imm(dout) || has_abs(dout)) ? S_OPLO : S_EXEC;
      end

      S_OPLO: begin
        ceb_c   = 1'b1;
        adb_c   = pc_q;
        pc_d    = pc_q + 13'd1;
        ret_d   = has_abs(ir_q) ? S_OPHI : S_EXEC;
        state_d = S_WAIT;
      end

      S_OPHI: begin
        lo_d    = dout;
        ceb_c   = 1'b1;
        adb_c   = pc_q;
        pc_d    = pc_q + 13'd1;
        ret_d   = S_EXEC;
        state_d = S_WAIT;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q)
          OP_LDAI: begin
            a_d = dout;
            z_d = (dout == 8'h00);
          end
          OP_LDAA: begin
            ceb_c   = 1'b1;
            adb_c   = abs_addr;
            ret_d   = S_MEMRD;
            state_d = S_WAIT;
          end
          OP_STA: begin
            cea_c = 1'b1;
            ada_c = abs_addr;
            din_c = a_q;
          end
          OP_LDXI: begin
            x_d = dout;
            z_d = (dout == 8'h00);
          end
          OP_INX: begin
            x_d = x_inc;
            z_d = (x_inc == 8'h00);
          end
          OP_ADDI: begin
            a_d = sum9[7:0];
            c_d = sum9[8];
            z_d = (sum9[7:0] == 8'h00);
          end
          OP_SUBI: begin
            a_d = diff9[7:0];
            c_d = diff9[8];
            z_d = (diff9[7:0] == 8'h00);
          end
          OP_CMPI: begin
            c_d = diff9[8];
            z_d = (diff9[7:0] == 8'h00);
          end
          OP_JMP: pc_d = abs_addr;
          OP_JNZ: begin
            if (!z_q) pc_d = abs_addr;
          end
          OP_STV: begin
            v_cea_c = 1'b1;
            v_ada_c = abs_addr[9:0];
            v_din_c = a_q;
          end
          OP_STVX: begin
            v_cea_c = 1'b1;
            v_ada_c = stvx_addr;
            v_din_c = a_q;
          end
          OP_WVS: state_d = S_VWAIT;
          OP_HLT: state_d = S_HALT;
          OP_NOP: ;
          default: ;  // undefined opcodes behave as NOP
        endcase
      end

      S_MEMRD: begin
        a_d     = dout;
        z_d     = (dout == 8'h00);
        state_d = S_FETCH;
      end

      // The edge detector runs continuously, but only a rise seen while
      // parked here releases the stall; a level already high on entry
      // produces no edge.
      S_VWAIT: begin
        if (vs_rise) state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // The reset state is S_FETCH, which would otherwise drive a read; gating
  // with the reset keeps every output at 0 while reset is held and drops a
  // pending strobe the moment reset asserts.
  assign din   = rst_n ? '0 : din_c;
  assign ada   = rst_n ? '0 : ada_c;
  assign cea   = cea_c & ~rst_n;
  assign adb   = rst_n ? '0 : adb_c;
  assign ceb   = ceb_c & ~rst_n;
  assign v_din = rst_n ? '0 : v_din_c;
  assign v_ada = rst_n ? '0 : v_ada_c;
  assign v_cea = v_cea_c & ~rst_n;

endmodule

// File: tb/tb_lcd_cpu.sv
module tb_lcd_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        vsync = 1'b0;
  logic [7:0]  dout = 8'h00;
  logic [7:0]  din;
  logic [12:0] ada;
  logic        cea;
  logic [12:0] adb;
  logic        ceb;
  logic [7:0]  v_din;
  logic [9:0]  v_ada;
  logic        v_cea;

`ifdef VSYNC_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  lcd_cpu #(.RESET_PC(13'h0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .dout (dout),
    .din  (din),
    .ada  (ada),
    .cea  (cea),
    .adb  (adb),
    .ceb  (ceb),
    .v_din(v_din),
    .v_ada(v_ada),
    .v_cea(v_cea)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];

  always @(posedge clk) begin
    if (ceb) dout <= mem[adb];
    if (cea) mem[ada] = din;
  end

  // Activity monitor, cleared while reset is held.
  int         n_vst, n_st, n_both, n_hit, cyc, last_ceb;
  logic [9:0] last_vada;
  logic [7:0] last_vdin;
  logic [12:0] last_ada;
  logic [7:0] last_din;

  always @(negedge clk) begin
    if (rst_n) begin
      n_vst = 0; n_st = 0; n_both = 0; n_hit = 0; cyc = 0; last_ceb = 0;
      last_vada = '0; last_vdin = '0; last_ada = '0; last_din = '0;
    end else begin
      if (v_cea) begin n_vst++; last_vada = v_ada; last_vdin = v_din; end
      if (cea) begin n_st++; last_ada = ada; last_din = din; end
      if (cea && v_cea) n_both++;
      if (ceb) begin
        last_ceb = cyc;
        if (adb == 13'h1000) n_hit++;
      end
      cyc++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] prog[$];

  task automatic start_prog(input int ncyc);
    rst_n = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk(tag, {ceb, cea, v_cea, adb, ada, din, v_ada, v_din}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset_outputs");
    chk("reset_pc", dut.pc_q, 13'h0000);
    chk("reset_regs", {dut.a_q, dut.x_q, dut.z_q, dut.c_q}, 32'h0);

    // LDA #41; STV 0005; HLT
    prog = {8'h01, 8'h41, 8'h0B, 8'h05, 8'h00, 8'hFF};
    start_prog(200);
    chk("t1_vst_count", n_vst, 1);
    chk("t1_vada", last_vada, 10'h005);
    chk("t1_vdin", last_vdin, 8'h41);
    chk("t1_ram_writes", n_st, 0);
    chk("t1_ceb_idle", (cyc - last_ceb) > 100, 1);
    chk("t1_pc_frozen", dut.pc_q, 13'h0006);

    // LDA #FE; ADD #03; HLT
    prog = {8'h01, 8'hFE, 8'h06, 8'h03, 8'hFF};
    start_prog(150);
    chk("t2_a", dut.a_q, 8'h01);
    chk("t2_zc", {dut.z_q, dut.c_q}, 2'b01);

    // LDA #05; SUB #05; JNZ 1000; HLT
    prog = {8'h01, 8'h05, 8'h07, 8'h05, 8'h0A, 8'h00, 8'h10, 8'hFF};
    start_prog(150);
    chk("t3_a", dut.a_q, 8'h00);
    chk("t3_zc", {dut.z_q, dut.c_q}, 2'b10);
    chk("t3_no_jump", n_hit, 0);
    chk("t3_pc", dut.pc_q, 13'h0008);

    // LDX #FF; INX; STVX 0300; HLT
    prog = {8'h04, 8'hFF, 8'h05, 8'h0C, 8'h00, 8'h03, 8'hFF};
    start_prog(150);
    chk("t4_x", dut.x_q, 8'h00);
    chk("t4_z", dut.z_q, 1'b1);
    chk("t4_vst_count", n_vst, 1);
    chk("t4_vada", last_vada, 10'h300);
    chk("t4_vdin", last_vdin, 8'h00);

    // LDA #77; STA 1000; LDA 1000; HLT
    prog = {8'h01, 8'h77, 8'h03, 8'h00, 8'h10, 8'h02, 8'h00, 8'h10, 8'hFF};
    start_prog(200);
    chk("t5_st_count", n_st, 1);
    chk("t5_ada", last_ada, 13'h1000);
    chk("t5_din", last_din, 8'h77);
    chk("t5_ram", mem[13'h1000], 8'h77);
    chk("t5_a", dut.a_q, 8'h77);
    chk("t5_no_vram", n_vst, 0);
    chk("t5_no_conflict", n_both, 0);

    // WVS; LDA #AA; STV 0000; HLT  with vsync already high
    vsync = 1'b1;
    prog = {8'h0D, 8'h01, 8'hAA, 8'h0B, 8'h00, 8'h00, 8'hFF};
    start_prog(60);
    chk("t6_stall_vst", n_vst, 0);
    chk("t6_stall_pc", dut.pc_q, 13'h0001);
    chk("t6_stall_ceb", ceb, 1'b0);
    vsync = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_fall_no_release", n_vst, 0);
    vsync = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1 chk("t6_early_ceb", ceb, 1'b0);
    @(posedge clk);
    #1 chk("t6_release_ceb", {ceb, adb}, {1'b1, 13'h0001});
    repeat (60) @(negedge clk);
    chk("t6_vst_count", n_vst, 1);
    chk("t6_vdin", last_vdin, 8'hAA);
    chk("t6_vada", last_vada, 10'h000);

    // Reset during the stall
    start_prog(30);
    chk("t7_stalled_pc", dut.pc_q, 13'h0001);
    #2 rst_n = 1'b1;
    #1 chk_idle_outputs("t7_reset_outputs");
    chk("t7_reset_pc", dut.pc_q, 13'h0000);
    vsync = 1'b0;

    // Reset while a VRAM strobe is high must drop it immediately
    prog = {8'h01, 8'h41, 8'h0B, 8'h05, 8'h00, 8'hFF};
    start_prog(1);
    begin
      int k;
      k = 0;
      while (!v_cea && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("t8_strobe_seen", v_cea, 1'b1);
    end
    #2 rst_n = 1'b1;
    #1 chk("t8_strobe_drop", {v_cea, v_ada, v_din}, 19'h0);
    chk("t8_reset_a", dut.a_q, 8'h00);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
